// File: rtl/seq_serializer_if.sv
// Handshake bundle for seq_serializer: parallel word input plus the serial seq/valid/last stream.
// The master modport is the serializer itself; slave is the surrounding producer/consumer.
interface seq_serializer_if #(
    parameter int unsigned WORD_WIDTH = 8
) ();
    logic [WORD_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  m_ready;
    logic                  seq;
    logic                  valid;
    logic                  last;
    logic                  busy;

    modport master (
        input  s_data,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output seq,
        output valid,
        output last,
        output busy
    );

    modport slave (
        output s_data,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  seq,
        input  valid,
        input  last,
        input  busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Word FIFO feeding a shift register that emits one bit per cycle with valid/last framing.
// Define SEQ_SERIALIZER_LSB_FIRST_EN to emit bit 0 first; default build is MSB first.
module seq_serializer #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_serializer_if.master bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(WORD_WIDTH);
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] LastBit   = CntW'(WORD_WIDTH - 1);

`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    typedef enum logic [0:0] {
        StEmpty,
        StShift
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         count_q, count_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic at_last;

    // Full/empty come from registered occupancy only, so m_ready never reaches s_ready.
    assign fifo_full   = (count_q == FullCount);
    assign fifo_empty  = (count_q == '0);
    assign bus.s_ready = !fifo_full && !reset;
    assign push        = bus.s_valid && bus.s_ready;
    assign at_last     = (cnt_q == LastBit);

    assign bus.seq   = LsbFirst ? shreg_q[0] : shreg_q[WORD_WIDTH-1];
    assign bus.valid = (state_q == StShift);
    assign bus.last  = (state_q == StShift) && at_last;
    assign bus.busy  = (state_q == StShift) || !fifo_empty;

    // Shifter FSM; the final bit of a word pops the next one on the same edge to avoid a bubble.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.m_ready) begin
                    if (at_last) begin
                        if (fifo_empty) begin
                            state_d = StEmpty;
                        end else begin
                            pop     = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d = LsbFirst ? {1'b0, shreg_q[WORD_WIDTH-1:1]}
                                           : {shreg_q[WORD_WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEmpty;
            shreg_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) pop |-> !fifo_empty);

    a_stall_holds: assert property (@(posedge clk) disable iff (reset)
        bus.valid && !bus.m_ready |=> bus.valid && $stable(bus.seq) && $stable(bus.last));

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: accepted words queue their expected bits, emitted bits pop.
// Bit order of the model follows SEQ_SERIALIZER_LSB_FIRST_EN, as in the design.
module tb_seq_serializer;

    typedef struct packed {
        logic bit_val;
        logic is_last;
    } exp_t;

`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seq_serializer_if #(.WORD_WIDTH(8)) bus ();

    seq_serializer #(
        .WORD_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_accepted = 0;

    // Drive inputs at the falling edge, settle, and queue expected bits of any accepted word.
    task automatic tick(input logic sv, input logic [7:0] d, input logic mr, input logic rst);
        exp_t e;
        @(negedge clk);
        bus.s_valid = sv;
        bus.s_data  = d;
        bus.m_ready = mr;
        reset       = rst;
        #1;
        if (bus.s_valid && bus.s_ready) begin
            n_accepted++;
            for (int i = 0; i < 8; i++) begin
                e.bit_val = LsbFirst ? d[i] : d[7-i];
                e.is_last = (i == 7);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'hC3, 1'b1, 1'b1);
            n_checks++;
            if ({bus.s_ready, bus.seq, bus.valid, bus.last, bus.busy} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_outputs: cycle %0d ready,seq,valid,last,busy=%b required 00000",
                         i, {bus.s_ready, bus.seq, bus.valid, bus.last, bus.busy});
            end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", bus.s_ready);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({bus.busy, bus.valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_no_word: busy,valid=%b required 00", {bus.busy, bus.valid});
        end
    endtask

    task automatic test_single_word();
        exp_t       e;
        int         first_valid = -1;
        int         n_valid     = 0;
        int         det_at      = -1;
        logic [4:0] hist        = '0;
        int         det_exp     = LsbFirst ? 7 : 5;
        tick(1'b1, 8'hB6, 1'b1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.valid) begin
                if (first_valid < 0) first_valid = c;
                n_valid++;
                hist = {hist[3:0], bus.seq};
                if (hist == 5'b10110 && det_at < 0) det_at = n_valid;
            end
            if (bus.valid && bus.m_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_bit: unexpected bit seq=%b with empty scoreboard", bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL single_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        n_checks++;
        if (first_valid != 2) begin
            n_fail++;
            $display("FAIL single_latency: first valid cycle %0d required 2", first_valid);
        end
        n_checks++;
        if (n_valid != 8) begin
            n_fail++;
            $display("FAIL single_count: %0d valid cycles required 8", n_valid);
        end
        n_checks++;
        if (det_at != det_exp) begin
            n_fail++;
            $display("FAIL single_detect: 10110 completed at bit %0d required %0d", det_at, det_exp);
        end
        n_checks++;
        if (sb_q.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drained: pending=%0d busy=%b required 0 and 0",
                     sb_q.size(), bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] words [2] = '{8'hB6, 8'h5A};
        int         acc0      = n_accepted;
        int         first     = -1;
        int         lastc     = -1;
        int         n_valid   = 0;
        for (int c = 0; c < 24; c++) begin
            tick(c < 2, (c < 2) ? words[c] : 8'h00, 1'b1, 1'b0);
            if (bus.valid) begin
                if (first < 0) first = c;
                lastc = c;
                n_valid++;
            end
            if (bus.valid && bus.m_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_bit: unexpected bit seq=%b with empty scoreboard", bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL b2b_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        n_checks++;
        if (n_accepted - acc0 != 2) begin
            n_fail++;
            $display("FAIL b2b_accept: %0d words accepted required 2", n_accepted - acc0);
        end
        n_checks++;
        if (n_valid != 16 || lastc - first != 15) begin
            n_fail++;
            $display("FAIL b2b_contiguous: %0d valid over span %0d required 16 over 16",
                     n_valid, lastc - first + 1);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   k       = 1;
        int   acc0    = n_accepted;
        int   n_drain = 0;
        for (int c = 0; c < 12; c++) begin
            tick(k <= 6, k[7:0], 1'b0, 1'b0);
            if (bus.s_valid && bus.s_ready) k++;
            if (bus.valid) begin
                n_checks++;
                if (sb_q.size() == 0 || bus.seq !== sb_q[0].bit_val || bus.last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: seq,last=%b%b while stalled on first bit",
                             bus.seq, bus.last);
                end
            end
        end
        n_checks++;
        if (n_accepted - acc0 != 5) begin
            n_fail++;
            $display("FAIL bp_accepted: %0d words accepted required 5", n_accepted - acc0);
        end
        n_checks++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: s_ready=%b required 0", bus.s_ready);
        end
        for (int c = 0; c < 60; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.valid && bus.m_ready) begin
                n_drain++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_drain_bit: unexpected bit seq=%b with empty scoreboard",
                             bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL bp_drain_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        n_checks++;
        if (n_drain != 40) begin
            n_fail++;
            $display("FAIL bp_drain_count: %0d bits drained required 40", n_drain);
        end
    endtask

    task automatic test_stall_toggle();
        exp_t e;
        int   n_valid = 0;
        for (int c = 0; c < 24; c++) begin
            tick(c == 0, 8'hA5, c[0], 1'b0);
            if (bus.valid) n_valid++;
            if (bus.valid && !bus.m_ready) begin
                n_checks++;
                if (sb_q.size() == 0 || {bus.seq, bus.last} !== {sb_q[0].bit_val, sb_q[0].is_last})
                begin
                    n_fail++;
                    $display("FAIL stall_hold: seq,last=%b%b differ from pending bit",
                             bus.seq, bus.last);
                end
            end
            if (bus.valid && bus.m_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_bit: unexpected bit seq=%b with empty scoreboard", bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL stall_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        n_checks++;
        if (n_valid != 16 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: %0d valid cycles, %0d bits pending required 16 and 0",
                     n_valid, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [7:0] words [3] = '{8'hFF, 8'h0D, 8'h33};
        int         n_bits    = 0;
        int         n_after   = 0;
        for (int c = 0; c < 20 && n_bits < 3; c++) begin
            tick(c < 3, (c < 3) ? words[c] : 8'h00, 1'b1, 1'b0);
            if (bus.valid && bus.m_ready) begin
                n_bits++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL midrst_bit: unexpected bit seq=%b with empty scoreboard", bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL midrst_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({bus.valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_flush: valid,busy=%b required 00", {bus.valid, bus.busy});
        end
        sb_q.delete();
        for (int c = 0; c < 16; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.valid) n_after++;
        end
        n_checks++;
        if (n_after != 0 || n_bits != 3) begin
            n_fail++;
            $display("FAIL midrst_discard: %0d bits after reset, %0d before; required 0 and 3",
                     n_after, n_bits);
        end
    endtask

    task automatic test_bit_order();
        exp_t       e;
        logic [7:0] got     = '0;
        logic [7:0] exp_seq = LsbFirst ? 8'b1011_0000 : 8'b0000_1101;
        tick(1'b1, 8'h0D, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (bus.valid && bus.m_ready) begin
                got = {got[6:0], bus.seq};
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL order_bit: unexpected bit seq=%b with empty scoreboard", bus.seq);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.seq, bus.last} !== {e.bit_val, e.is_last}) begin
                        n_fail++;
                        $display("FAIL order_bit: seq,last=%b%b required %b%b",
                                 bus.seq, bus.last, e.bit_val, e.is_last);
                    end
                end
            end
        end
        n_checks++;
        if (got !== exp_seq) begin
            n_fail++;
            $display("FAIL order_0x0D: emitted %b required %b", got, exp_seq);
        end
    endtask

    initial begin
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        bus.m_ready = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_stall_toggle();
        test_reset_mid();
        test_bit_order();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
